// File: rtl/kronos_branch_resolve.sv
// kronos_branch_resolve
// Resolves a decoded BRANCH/JAL/JALR. It computes the target address and then does one of three things:
//  - It redirects fetch through a valid/ready handshake and flushes younger instructions.
//  - For jumps, it pulses the link value (pc+4).
//  - For a misaligned target, it pulses a misalign trap request instead.
// Every response appears one cycle after the op is accepted.
module kronos_branch_resolve #(
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_vld,
  output logic        decode_rdy,
  input  logic [1:0]  decode_jtype,
  input  logic        decode_taken,
  input  logic [31:0] decode_pc,
  input  logic [31:0] decode_rs1,
  input  logic [31:0] decode_imm,
  output logic        redirect_vld,
  input  logic        redirect_rdy,
  output logic [31:0] redirect_addr,
  output logic        flush,
  output logic        link_vld,
  output logic [31:0] link_data,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  localparam logic [1:0] JT_NONE   = 2'b00;
  localparam logic [1:0] JT_BRANCH = 2'b01;
  localparam logic [1:0] JT_JAL    = 2'b10;
  localparam logic [1:0] JT_JALR   = 2'b11;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] redirect_addr_q, redirect_addr_d;
  logic        link_vld_q, link_vld_d;
  logic [31:0] link_data_q, link_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  logic        accept;
  logic        is_jump;
  logic        taken;
  logic [31:0] target;

  assign decode_rdy = (state_q == ST_IDLE);
  assign accept     = decode_vld & decode_rdy;
  assign is_jump    = (decode_jtype == JT_JAL) | (decode_jtype == JT_JALR);
  assign taken      = is_jump | ((decode_jtype == JT_BRANCH) & decode_taken);

  // Target address: JALR is register-relative with bit 0 forced low, the rest are pc-relative
  always_comb begin
    target = decode_pc + decode_imm;
    if (decode_jtype == JT_JALR) begin
      target = (decode_rs1 + decode_imm) & ~32'h1;
    end
  end

  // Next-state logic: the redirect is held until fetch takes it, and link/misalign are single-cycle pulses
  always_comb begin
    state_d         = state_q;
    redirect_addr_d = redirect_addr_q;
    link_vld_d      = 1'b0;
    link_data_d     = link_data_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (state_q == ST_REDIRECT) begin
      if (redirect_rdy) begin
        state_d = ST_IDLE;
      end
    end else if (accept && taken && (decode_jtype != JT_NONE)) begin
      if (target[1]) begin
        misalign_d      = 1'b1;
        misalign_addr_d = target;
      end else begin
        state_d         = ST_REDIRECT;
        redirect_addr_d = target;
        link_vld_d      = is_jump;
        if (is_jump) begin
          link_data_d = decode_pc + 32'd4;
        end
      end
    end
  end

  // State and response registers; reset drops any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      redirect_addr_q <= RESET_ADDR;
      link_vld_q      <= 1'b0;
      link_data_q     <= 32'h0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= RESET_ADDR;
    end else begin
      state_q         <= state_d;
      redirect_addr_q <= redirect_addr_d;
      link_vld_q      <= link_vld_d;
      link_data_q     <= link_data_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign redirect_vld  = (state_q == ST_REDIRECT);
  assign flush         = (state_q == ST_REDIRECT);
  assign redirect_addr = redirect_addr_q;
  assign link_vld      = link_vld_q;
  assign link_data     = link_data_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_kronos_branch_resolve.sv
// Testbench for kronos_branch_resolve.
// It applies a table of single ops, then hand-written multi-cycle sequences, then a randomized run
// that is compared against a small cycle model.
module tb_kronos_branch_resolve;

  localparam logic [31:0] RST_ADDR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic        decode_vld;
  logic        decode_rdy;
  logic [1:0]  decode_jtype;
  logic        decode_taken;
  logic [31:0] decode_pc;
  logic [31:0] decode_rs1;
  logic [31:0] decode_imm;
  logic        redirect_vld;
  logic        redirect_rdy;
  logic [31:0] redirect_addr;
  logic        flush;
  logic        link_vld;
  logic [31:0] link_data;
  logic        misalign;
  logic [31:0] misalign_addr;

  int compared = 0;
  int mismatched = 0;

  kronos_branch_resolve #(.RESET_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst(rst),
    .decode_vld(decode_vld), .decode_rdy(decode_rdy),
    .decode_jtype(decode_jtype), .decode_taken(decode_taken),
    .decode_pc(decode_pc), .decode_rs1(decode_rs1), .decode_imm(decode_imm),
    .redirect_vld(redirect_vld), .redirect_rdy(redirect_rdy), .redirect_addr(redirect_addr),
    .flush(flush), .link_vld(link_vld), .link_data(link_data),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  jtype;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic        expRedir;
    logic [31:0] expAddr;
    logic        expLink;
    logic [31:0] expLinkData;
    logic        expMis;
    logic [31:0] expMisAddr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] jt, input logic tk,
                               input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm);
    decode_vld   = vld;
    decode_jtype = jt;
    decode_taken = tk;
    decode_pc    = pc;
    decode_rs1   = rs1;
    decode_imm   = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " redirect_vld"}, {31'b0, redirect_vld}, 32'd0);
    checkOutput({tag, " flush"}, {31'b0, flush}, 32'd0);
    checkOutput({tag, " link_vld"}, {31'b0, link_vld}, 32'd0);
    checkOutput({tag, " misalign"}, {31'b0, misalign}, 32'd0);
    checkOutput({tag, " decode_rdy"}, {31'b0, decode_rdy}, 32'd1);
  endtask

  // Randomized-run model state
  logic        mState, mLink, mMis;
  logic [31:0] mAddr, mLinkData, mMisAddr;

  // Main stimulus
  initial begin
    vecs[0] = '{2'b01, 1'b1, 32'h0000_1000, 32'h0, 32'h0000_0010, 1'b1, 32'h0000_1010, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{2'b01, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{2'b00, 1'b1, 32'h0000_1000, 32'h0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3] = '{2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0006, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0206};
    vecs[4] = '{2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0020, 1'b1, 32'h0000_0010, 1'b1, 32'hFFFF_FFF4, 1'b0, 32'h0};
    vecs[5] = '{2'b11, 1'b0, 32'h0000_0040, 32'h0000_1001, 32'h0000_0004, 1'b1, 32'h0000_1004, 1'b1, 32'h0000_0044, 1'b0, 32'h0};
    vecs[6] = '{2'b11, 1'b0, 32'h0000_0040, 32'h0000_1003, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_1002};
    vecs[7] = '{2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'hFFFF_FFF0, 1'b1, 32'h0000_00F0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[8] = '{2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0002, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0102};
    vecs[9] = '{2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_FF00, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0304, 1'b0, 32'h0};

    rst = 1'b1;
    redirect_rdy = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    checkQuiet("reset");
    checkOutput("reset redirect_addr", redirect_addr, RST_ADDR);
    checkOutput("reset misalign_addr", misalign_addr, RST_ADDR);
    checkOutput("reset link_data", link_data, 32'h0);
    rst = 1'b0;

    // Table of single ops with fetch always ready
    redirect_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].jtype, vecs[i].taken, vecs[i].pc, vecs[i].rs1, vecs[i].imm);
      tick();
      decode_vld = 1'b0;
      checkOutput($sformatf("vec%0d redirect_vld", i), {31'b0, redirect_vld}, {31'b0, vecs[i].expRedir});
      checkOutput($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].expRedir});
      checkOutput($sformatf("vec%0d decode_rdy", i), {31'b0, decode_rdy}, {31'b0, ~vecs[i].expRedir});
      checkOutput($sformatf("vec%0d link_vld", i), {31'b0, link_vld}, {31'b0, vecs[i].expLink});
      checkOutput($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].expMis});
      if (vecs[i].expRedir) checkOutput($sformatf("vec%0d redirect_addr", i), redirect_addr, vecs[i].expAddr);
      if (vecs[i].expLink) checkOutput($sformatf("vec%0d link_data", i), link_data, vecs[i].expLinkData);
      if (vecs[i].expMis) checkOutput($sformatf("vec%0d misalign_addr", i), misalign_addr, vecs[i].expMisAddr);
      tick();
      checkQuiet($sformatf("vec%0d after", i));
    end

    // Held redirect: fetch stalls three cycles, and decode ops offered meanwhile are ignored
    redirect_rdy = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0020);
    tick();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 32'h0000_0008);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("hold%0d redirect_vld", c), {31'b0, redirect_vld}, 32'd1);
      checkOutput($sformatf("hold%0d flush", c), {31'b0, flush}, 32'd1);
      checkOutput($sformatf("hold%0d decode_rdy", c), {31'b0, decode_rdy}, 32'd0);
      checkOutput($sformatf("hold%0d redirect_addr", c), redirect_addr, 32'h0000_0120);
      checkOutput($sformatf("hold%0d link_vld", c), {31'b0, link_vld}, 32'd0);
      tick();
    end
    decode_vld = 1'b0;
    redirect_rdy = 1'b1;
    checkOutput("hold3 redirect_addr", redirect_addr, 32'h0000_0120);
    checkOutput("hold3 redirect_vld", {31'b0, redirect_vld}, 32'd1);
    tick();
    checkQuiet("hold release");
    checkOutput("hold release redirect_addr", redirect_addr, 32'h0000_0120);

    // Back-to-back not-taken branches are all accepted
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0100 + 32'(c * 4), 32'h0, 32'h0000_0040);
      tick();
      checkQuiet($sformatf("nt%0d", c));
    end
    decode_vld = 1'b0;

    // Link pulse lasts only the entry cycle while the redirect is still held
    redirect_rdy = 1'b0;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_0100);
    tick();
    decode_vld = 1'b0;
    checkOutput("lp entry link_vld", {31'b0, link_vld}, 32'd1);
    checkOutput("lp entry link_data", link_data, 32'h0000_0404);
    checkOutput("lp entry redirect_addr", redirect_addr, 32'h0000_0500);
    tick();
    checkOutput("lp second link_vld", {31'b0, link_vld}, 32'd0);
    checkOutput("lp second redirect_vld", {31'b0, redirect_vld}, 32'd1);
    redirect_rdy = 1'b1;
    tick();
    checkQuiet("lp release");

    // Misalign pulse followed immediately by a not-taken op
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0006);
    tick();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0204, 32'h0, 32'h0000_0010);
    checkOutput("mis pulse misalign", {31'b0, misalign}, 32'd1);
    checkOutput("mis pulse misalign_addr", misalign_addr, 32'h0000_0206);
    checkOutput("mis pulse decode_rdy", {31'b0, decode_rdy}, 32'd1);
    tick();
    decode_vld = 1'b0;
    checkQuiet("mis after");

    // Reset in the middle of a stalled redirect
    redirect_rdy = 1'b0;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0000_0040);
    tick();
    decode_vld = 1'b0;
    checkOutput("mid redirect_vld", {31'b0, redirect_vld}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkQuiet("midrst");
    checkOutput("midrst redirect_addr", redirect_addr, RST_ADDR);
    checkOutput("midrst misalign_addr", misalign_addr, RST_ADDR);
    checkOutput("midrst link_data", link_data, 32'h0);
    redirect_rdy = 1'b1;
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_0010);
    tick();
    decode_vld = 1'b0;
    checkOutput("postrst redirect_vld", {31'b0, redirect_vld}, 32'd1);
    checkOutput("postrst redirect_addr", redirect_addr, 32'h0000_0020);
    tick();
    checkQuiet("postrst after");

    // Randomized run compared against a cycle model
    mState = 1'b0; mLink = 1'b0; mMis = 1'b0;
    mAddr = 32'h0000_0020; mLinkData = 32'h0; mMisAddr = RST_ADDR;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r, tgt, pc, rs1, imm;
      logic [1:0]  jt;
      logic        tk, vld, rdy, isJump, isTaken;
      r   = $urandom;
      vld = r[0];
      jt  = r[2:1];
      tk  = r[3];
      rdy = (r[5:4] != 2'b00);
      pc  = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom;
      imm = $urandom & 32'h0000_0FFF;
      if (imm[11]) imm = imm | 32'hFFFF_F000;
      applyStimulus(vld, jt, tk, pc, rs1, imm);
      redirect_rdy = rdy;
      isJump  = jt[1];
      isTaken = isJump || (jt == 2'b01 && tk);
      tgt = (jt == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      mLink = 1'b0;
      mMis  = 1'b0;
      if (mState) begin
        if (rdy) mState = 1'b0;
      end else if (vld && isTaken) begin
        if (tgt[1]) begin
          mMis = 1'b1;
          mMisAddr = tgt;
        end else begin
          mState = 1'b1;
          mAddr = tgt;
          mLink = isJump;
          if (isJump) mLinkData = pc + 32'd4;
        end
      end
      tick();
      checkOutput("rnd redirect_vld", {31'b0, redirect_vld}, {31'b0, mState});
      checkOutput("rnd flush", {31'b0, flush}, {31'b0, mState});
      checkOutput("rnd decode_rdy", {31'b0, decode_rdy}, {31'b0, ~mState});
      checkOutput("rnd link_vld", {31'b0, link_vld}, {31'b0, mLink});
      checkOutput("rnd misalign", {31'b0, misalign}, {31'b0, mMis});
      if (mState) checkOutput("rnd redirect_addr", redirect_addr, mAddr);
      if (mLink) checkOutput("rnd link_data", link_data, mLinkData);
      if (mMis) checkOutput("rnd misalign_addr", misalign_addr, mMisAddr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
